// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder: FSM state enums,
// the NOP word returned for out-of-range fetches, and default RAM depths.
package mem_resp_pkg;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } top_state_e;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_VALID
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int unsigned IMEM_DEPTH_DEF = 1024;
    localparam int unsigned DMEM_DEPTH_DEF = 4096;
    localparam int unsigned INST_WAIT_DEF  = 2;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-facing bundle of the memory responder: boot load stream, instruction
// fetch port and data port. master = CPU/loader side, slave = responder.
interface mem_responder_if;

    logic        BOOT_VALID;
    logic [31:0] BOOT_DATA;
    logic        BOOT_LAST;
    logic        BOOT_READY;
    logic        BOOT_DONE;

    logic [31:0] ADDR;
    logic [31:0] MEM_INST;
    logic        MEM_INST_ENB;

    logic [15:0] MEM_ADDR;
    logic [31:0] MEM_STORE;
    logic        MEM_WRITE_ENABLE;
    logic [31:0] MEM_LOAD;

    modport master (
        output BOOT_VALID, BOOT_DATA, BOOT_LAST,
        output ADDR,
        output MEM_ADDR, MEM_STORE, MEM_WRITE_ENABLE,
        input  BOOT_READY, BOOT_DONE,
        input  MEM_INST, MEM_INST_ENB,
        input  MEM_LOAD
    );

    modport slave (
        input  BOOT_VALID, BOOT_DATA, BOOT_LAST,
        input  ADDR,
        input  MEM_ADDR, MEM_STORE, MEM_WRITE_ENABLE,
        output BOOT_READY, BOOT_DONE,
        output MEM_INST, MEM_INST_ENB,
        output MEM_LOAD
    );

endinterface

// File: rtl/mem_sp_ram.sv
// Generic single-port synchronous RAM with a registered, write-first read port.
// The read register only updates on cycles where en is high.
module mem_sp_ram #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array sits in a clock-only block with no reset so it maps onto
    // RAM macros; only the read register below is reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // NOTE: sequential state always uses <= so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: boots instruction RAM from a stream, then serves fetches
// and data accesses. Define MEM_RESP_WAIT_EN to stretch fetch WAIT by INST_WAIT.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int unsigned DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter int unsigned INST_WAIT  = INST_WAIT_DEF
) (
    input logic            CLK,
    input logic            RST,
    mem_responder_if.slave bus
);

    localparam int unsigned IW = $clog2(IMEM_DEPTH);
    localparam int unsigned DW = $clog2(DMEM_DEPTH);

    top_state_e    state;
    logic [IW-1:0] wptr;
    logic          boot_ready;
    logic          boot_done;
    logic          boot_fire;
    logic          run;

    fetch_state_e  fstate;
    logic [29:0]   last_word;
    logic          last_valid;
    logic          last_oor;
    logic [31:0]   mem_inst;
    logic          mem_inst_enb;
    logic [IW-1:0] fetch_idx;
    logic          fetch_oor;
    logic          fetch_restart;

    logic          imem_en;
    logic [IW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   dmem_rdata;

`ifdef MEM_RESP_WAIT_EN
    logic [3:0]    wait_cnt;
    logic          wait_done;
    assign wait_done = (wait_cnt == 4'd0);
`else
    logic          wait_done;
    assign wait_done = 1'b1;
    localparam int unsigned unused_inst_wait = INST_WAIT;
`endif

    // ADDR[1:0] selects a byte within the word and is never used.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.ADDR[1:0], bus.MEM_ADDR};

    assign boot_fire     = bus.BOOT_VALID && boot_ready;
    assign run           = (state == ST_RUN);
    assign fetch_idx     = bus.ADDR[IW+1:2];
    assign fetch_oor     = (bus.ADDR >> (IW + 2)) != '0;
    assign fetch_restart = run && (!last_valid || bus.ADDR[31:2] != last_word);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_BOOT;
            wptr       <= '0;
            boot_ready <= 1'b0;
            boot_done  <= 1'b0;
        end else if (state == ST_BOOT) begin
            boot_ready <= 1'b1;
            if (boot_fire) begin
                wptr <= wptr + IW'(1);
                if (bus.BOOT_LAST || wptr == IW'(IMEM_DEPTH - 1)) begin
                    state      <= ST_RUN;
                    boot_ready <= 1'b0;
                    boot_done  <= 1'b1;
                end
            end
        end else begin
            boot_ready <= 1'b0;
            boot_done  <= 1'b1;
        end
    end

    // A restart has priority over WAIT completion, so an address change on
    // the completing edge never delivers the stale word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fstate       <= F_IDLE;
            last_word    <= '0;
            last_valid   <= 1'b0;
            last_oor     <= 1'b0;
            mem_inst     <= NOP_WORD;
            mem_inst_enb <= 1'b0;
`ifdef MEM_RESP_WAIT_EN
            wait_cnt     <= '0;
`endif
        end else if (!run) begin
            fstate       <= F_IDLE;
            last_valid   <= 1'b0;
            mem_inst_enb <= 1'b0;
        end else if (fetch_restart) begin
            fstate       <= F_WAIT;
            last_word    <= bus.ADDR[31:2];
            last_valid   <= 1'b1;
            last_oor     <= fetch_oor;
            mem_inst_enb <= 1'b0;
`ifdef MEM_RESP_WAIT_EN
            wait_cnt     <= 4'(INST_WAIT);
`endif
        end else begin
            case (fstate)
                F_WAIT: begin
                    if (wait_done) begin
                        mem_inst     <= last_oor ? NOP_WORD : imem_rdata;
                        mem_inst_enb <= 1'b1;
                        fstate       <= F_VALID;
                    end
`ifdef MEM_RESP_WAIT_EN
                    else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Boot writer and fetch reader share the imem port; state keeps them apart.
    assign imem_en   = boot_fire || fetch_restart;
    assign imem_addr = (state == ST_BOOT) ? wptr : fetch_idx;

    mem_sp_ram #(
        .WIDTH (32),
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk   (CLK),
        .rst_n (RST),
        .en    (imem_en),
        .we    (boot_fire),
        .addr  (imem_addr),
        .wdata (bus.BOOT_DATA),
        .rdata (imem_rdata)
    );

    mem_sp_ram #(
        .WIDTH (32),
        .DEPTH (DMEM_DEPTH)
    ) u_dmem (
        .clk   (CLK),
        .rst_n (RST),
        .en    (run),
        .we    (run && bus.MEM_WRITE_ENABLE),
        .addr  (bus.MEM_ADDR[DW-1:0]),
        .wdata (bus.MEM_STORE),
        .rdata (dmem_rdata)
    );

    assign bus.BOOT_READY   = boot_ready;
    assign bus.BOOT_DONE    = boot_done;
    assign bus.MEM_INST     = mem_inst;
    assign bus.MEM_INST_ENB = mem_inst_enb;
    assign bus.MEM_LOAD     = dmem_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed boot/fetch/data steps plus
// randomized traffic compared against array-based reference memories.
module tb_mem_responder;

    localparam int unsigned IMEM_DEPTH = 8;
    localparam int unsigned DMEM_DEPTH = 64;
    localparam int unsigned INST_WAIT  = 2;
    localparam int unsigned IW         = $clog2(IMEM_DEPTH);
    localparam int unsigned DW         = $clog2(DMEM_DEPTH);
`ifdef MEM_RESP_WAIT_EN
    localparam int unsigned WAIT_EDGES = 1 + INST_WAIT;
`else
    localparam int unsigned WAIT_EDGES = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] imem_m [IMEM_DEPTH];
    logic [31:0] dmem_m [DMEM_DEPTH];
    logic [31:0] cur_addr;

    mem_responder_if bus();

    mem_responder #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .DMEM_DEPTH (DMEM_DEPTH),
        .INST_WAIT  (INST_WAIT)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_inst(input logic [31:0] a);
        logic [IW-1:0] w;
        if (a >= IMEM_DEPTH * 4) return 32'h0;
        w = a[IW+1:2];
        return imem_m[w];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.BOOT_READY),   32'd0);
        check({tag, "_done"},  32'(bus.BOOT_DONE),    32'd0);
        check({tag, "_inst"},  bus.MEM_INST,          32'd0);
        check({tag, "_enb"},   32'(bus.MEM_INST_ENB), 32'd0);
        check({tag, "_load"},  bus.MEM_LOAD,          32'd0);
    endtask

    task automatic boot_beat(input logic [31:0] d, input logic last, input string tag);
        check({tag, "_ready"}, 32'(bus.BOOT_READY), 32'd1);
        bus.BOOT_VALID = 1'b1;
        bus.BOOT_DATA  = d;
        bus.BOOT_LAST  = last;
        tick();
        bus.BOOT_VALID = 1'b0;
        bus.BOOT_LAST  = 1'b0;
    endtask

    // Drives a new fetch address, expects ENB low through WAIT, then the
    // model word with ENB high, and that it stays put on the following edge.
    task automatic fetch_check(input logic [31:0] a, input string tag);
        logic [31:0] exp;
        exp      = ref_inst(a);
        bus.ADDR = a;
        cur_addr = a;
        for (int k = 0; k < int'(WAIT_EDGES); k++) begin
            tick();
            check({tag, "_wait_enb"}, 32'(bus.MEM_INST_ENB), 32'd0);
        end
        tick();
        check({tag, "_enb"},  32'(bus.MEM_INST_ENB), 32'd1);
        check({tag, "_inst"}, bus.MEM_INST,          exp);
        tick();
        check({tag, "_hold_enb"},  32'(bus.MEM_INST_ENB), 32'd1);
        check({tag, "_hold_inst"}, bus.MEM_INST,          exp);
    endtask

    task automatic data_step(input logic [15:0] a, input logic we, input logic [31:0] d,
                             input string tag);
        logic [DW-1:0] di;
        di = DW'(a % DMEM_DEPTH);
        bus.MEM_ADDR         = a;
        bus.MEM_STORE        = d;
        bus.MEM_WRITE_ENABLE = we;
        tick();
        if (we) dmem_m[di] = d;
        check(tag, bus.MEM_LOAD, dmem_m[di]);
        bus.MEM_WRITE_ENABLE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] first_word;

        rst                  = 1'b0;
        bus.BOOT_VALID       = 1'b0;
        bus.BOOT_DATA        = '0;
        bus.BOOT_LAST        = 1'b0;
        bus.ADDR             = 32'd8;
        bus.MEM_ADDR         = '0;
        bus.MEM_STORE        = '0;
        bus.MEM_WRITE_ENABLE = 1'b0;
        cur_addr             = 32'd8;

        // Reset state, including READY held low across an edge in reset.
        #3;
        check_all_zero("reset");
        tick();
        check("reset_edge_ready", 32'(bus.BOOT_READY), 32'd0);
        #3 rst = 1'b1;
        tick();
        check("release_ready", 32'(bus.BOOT_READY), 32'd1);
        check("release_done",  32'(bus.BOOT_DONE),  32'd0);

        // Four-word boot with LAST; data writes during boot must be ignored.
        bus.MEM_ADDR         = 16'd3;
        bus.MEM_STORE        = 32'h0000_0BAD;
        bus.MEM_WRITE_ENABLE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d         = 32'h11 * (i + 1);
            imem_m[i] = d;
            boot_beat(d, i == 3, "boot4");
            check("boot4_load", bus.MEM_LOAD, 32'd0);
            check("boot4_enb", 32'(bus.MEM_INST_ENB), 32'd0);
        end
        bus.MEM_WRITE_ENABLE = 1'b0;
        check("boot4_done",  32'(bus.BOOT_DONE),  32'd1);
        check("boot4_ready", 32'(bus.BOOT_READY), 32'd0);

        // ADDR=8 was held through boot: word 2 after two edges.
        fetch_check(32'd8, "fetch_w2");
        check("fetch_w2_value", bus.MEM_INST, 32'h33);

        // Change 0 -> 4 during WAIT: only word 1 may ever be presented.
        bus.ADDR = 32'd0;
        tick();
        check("restart_first_enb", 32'(bus.MEM_INST_ENB), 32'd0);
        fetch_check(32'd4, "restart_w1");
        check("restart_w1_value", bus.MEM_INST, 32'h22);

        // Write-first and index wrap-around on the data port.
        data_step(16'd5, 1'b1, 32'hDEAD_BEEF, "wr_first");
        check("wr_first_value", bus.MEM_LOAD, 32'hDEAD_BEEF);
        dmem_m[10] = 32'hx;
        bus.MEM_ADDR = 16'd10;
        tick();
        data_step(16'(5 + DMEM_DEPTH), 1'b0, 32'h0, "wrap_read");
        check("wrap_read_value", bus.MEM_LOAD, 32'hDEAD_BEEF);

        // Asynchronous reset in RUN clears every output between edges.
        #2 rst = 1'b0;
        #1 check_all_zero("async_run");
        #3 rst = 1'b1;
        tick();
        check("reboot_ready", 32'(bus.BOOT_READY), 32'd1);

        // Two beats, then reset mid-boot; the next stream restarts at imem[0].
        boot_beat(32'h0000_00A0, 1'b0, "midboot");
        boot_beat(32'h0000_00A1, 1'b0, "midboot");
        #2 rst = 1'b0;
        #1 check_all_zero("async_boot");
        #3 rst = 1'b1;
        tick();

        // Eight beats without LAST fill IMEM_DEPTH=8 and enter RUN.
        for (int i = 0; i < int'(IMEM_DEPTH); i++) begin
            d         = $urandom;
            imem_m[i] = d;
            if (i == 0) first_word = d;
            boot_beat(d, 1'b0, "boot8");
            if (i < int'(IMEM_DEPTH) - 1)
                check("boot8_not_done", 32'(bus.BOOT_DONE), 32'd0);
        end
        check("boot8_done",  32'(bus.BOOT_DONE),  32'd1);
        check("boot8_ready", 32'(bus.BOOT_READY), 32'd0);

        // A ninth beat is refused and must not wrap onto imem[0].
        bus.BOOT_VALID = 1'b1;
        bus.BOOT_DATA  = 32'hFFFF_FFFF;
        bus.BOOT_LAST  = 1'b1;
        tick();
        check("beat9_ready", 32'(bus.BOOT_READY), 32'd0);
        check("beat9_done",  32'(bus.BOOT_DONE),  32'd1);
        bus.BOOT_VALID = 1'b0;
        bus.BOOT_LAST  = 1'b0;

        // Walk every word (with junk byte offsets), then out-of-range addresses.
        for (int i = 0; i < int'(IMEM_DEPTH); i++) begin
            fetch_check(32'(i * 4 + (i % 4)), "walk");
        end
        fetch_check(32'd0, "word0");
        check("word0_first_beat", bus.MEM_INST, first_word);
        fetch_check(32'(IMEM_DEPTH * 4), "oor_edge");
        check("oor_edge_nop", bus.MEM_INST, 32'h0);
        fetch_check(32'h8000_0008, "oor_high");

        // Random fetch addresses, mixing in-range and out-of-range words.
        for (int n = 0; n < 20; n++) begin
            do a = $urandom & 32'h0000_003F; while ((a >> 2) == (cur_addr >> 2));
            fetch_check(a, "rand_fetch");
        end

        // Fill data RAM, then random reads/writes with wrapped addresses.
        for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
            data_step(16'(i), 1'b1, $urandom, "fill");
        end
        for (int n = 0; n < 150; n++) begin
            data_step(16'($urandom), 1'($urandom_range(0, 1)), $urandom, "rand_data");
        end

        // Reset while a fetch is in WAIT.
        do a = $urandom & 32'h0000_001F; while ((a >> 2) == (cur_addr >> 2));
        bus.ADDR = a;
        tick();
        check("midfetch_enb", 32'(bus.MEM_INST_ENB), 32'd0);
        #2 rst = 1'b0;
        #1 check_all_zero("async_fetch");
        #3 rst = 1'b1;
        tick();
        check("final_ready", 32'(bus.BOOT_READY), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
